// File: rtl/host_cmd_pkg.sv
// host_cmd_pkg: opcodes, command and frame-state enums, and the
// per-command sequence helpers shared by the host command transmitter.
package host_cmd_pkg;

    localparam logic [7:0] OP_RF_WR   = 8'hAA;
    localparam logic [7:0] OP_RF_RD   = 8'hBB;
    localparam logic [7:0] OP_ALU_OP  = 8'hCC;
    localparam logic [7:0] OP_ALU_NOP = 8'hDD;

    typedef enum logic [1:0] {
        CMD_RF_WR   = 2'd0,
        CMD_RF_RD   = 2'd1,
        CMD_ALU_OP  = 2'd2,
        CMD_ALU_NOP = 2'd3
    } cmd_type_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } frame_state_e;

    function automatic logic [2:0] seq_len(input cmd_type_e t);
        logic [2:0] n;
        case (t)
            CMD_RF_WR:  n = 3'd3;
            CMD_RF_RD:  n = 3'd2;
            CMD_ALU_OP: n = 3'd4;
            default:    n = 3'd2;
        endcase
        return n;
    endfunction

    function automatic logic [7:0] opcode(input cmd_type_e t);
        logic [7:0] op;
        case (t)
            CMD_RF_WR:  op = OP_RF_WR;
            CMD_RF_RD:  op = OP_RF_RD;
            CMD_ALU_OP: op = OP_ALU_OP;
            default:    op = OP_ALU_NOP;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/uart_frame_tx.sv
// uart_frame_tx: single-byte UART serializer (start, 8 data LSB first,
// optional parity, stop). Ports: CLK/RST, BYTE_VALID/BYTE_READY/DATA,
// PAR_EN/PAR_TYP per byte, TX_OUT line, FRAME_DONE when nothing follows.
module uart_frame_tx
    import host_cmd_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       BYTE_VALID,
    output logic       BYTE_READY,
    input  logic [7:0] DATA,
    input  logic       PAR_EN,
    input  logic       PAR_TYP,
    output logic       TX_OUT,
    output logic       FRAME_DONE
);

    localparam logic [7:0] BAUD_LAST = 8'(CLKS_PER_BIT - 1);
    localparam logic [7:0] BAUD_PRE  = 8'(CLKS_PER_BIT - 2);

    frame_state_e r_state;
    frame_state_e w_next;
    logic [7:0]   r_baud;
    logic [2:0]   r_bit;
    logic [7:0]   r_shift;
    logic         r_par_en;
    logic         r_par_bit;
    logic         r_tx;
    logic         w_tx_bit;
    logic         w_load;
    logic         w_baud_last;

    assign w_baud_last = (r_baud == BAUD_LAST);
    assign w_load      = BYTE_READY && BYTE_VALID;
    assign TX_OUT      = r_tx;

    // The line is registered one cycle behind the state. On the final
    // stop bit the FSM drops to IDLE one cycle early; that IDLE cycle
    // still drives the last stop-bit cycle, so a byte accepted there
    // starts with no gap on the line.
    always_comb begin
        w_next     = r_state;
        w_tx_bit   = 1'b1;
        FRAME_DONE = 1'b0;
        BYTE_READY = 1'b0;
        case (r_state)
            ST_IDLE: begin
                BYTE_READY = 1'b1;
                if (BYTE_VALID) w_next = ST_START;
            end
            ST_START: begin
                w_tx_bit = 1'b0;
                if (w_baud_last) w_next = ST_DATA;
            end
            ST_DATA: begin
                w_tx_bit = r_shift[0];
                if (w_baud_last && r_bit == 3'd7)
                    w_next = r_par_en ? ST_PARITY : ST_STOP;
            end
            ST_PARITY: begin
                w_tx_bit = r_par_bit;
                if (w_baud_last) w_next = ST_STOP;
            end
            ST_STOP: begin
                if (!BYTE_VALID && r_baud >= BAUD_PRE) begin
                    w_next     = ST_IDLE;
                    FRAME_DONE = 1'b1;
                end else if (w_baud_last) begin
                    BYTE_READY = 1'b1;
                    w_next     = ST_START;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state   <= ST_IDLE;
            r_baud    <= '0;
            r_bit     <= '0;
            r_shift   <= '0;
            r_par_en  <= 1'b0;
            r_par_bit <= 1'b0;
            r_tx      <= 1'b1;
        end else begin
            r_state <= w_next;
            r_tx    <= w_tx_bit;
            if (r_state == ST_IDLE || w_next == ST_IDLE || w_baud_last)
                r_baud <= '0;
            else
                r_baud <= r_baud + 8'd1;
            if (r_state != ST_DATA)
                r_bit <= '0;
            else if (w_baud_last)
                r_bit <= r_bit + 3'd1;
            if (w_load) begin
                r_shift   <= DATA;
                r_par_en  <= PAR_EN;
                r_par_bit <= (^DATA) ^ PAR_TYP;
            end else if (r_state == ST_DATA && w_baud_last) begin
                r_shift <= {1'b0, r_shift[7:1]};
            end
        end
    end

endmodule

// File: rtl/host_cmd_tx.sv
// host_cmd_tx: accepts one command per handshake and streams its byte
// sequence (opcode + args) through uart_frame_tx. Ports: CMD_* handshake,
// ARG0..2, PAR_EN/PAR_TYP, TX_OUT line, BUSY, one-cycle DONE.
module host_cmd_tx
    import host_cmd_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       CMD_VALID,
    output logic       CMD_READY,
    input  logic [1:0] CMD_TYPE,
    input  logic [7:0] ARG0,
    input  logic [7:0] ARG1,
    input  logic [7:0] ARG2,
    input  logic       PAR_EN,
    input  logic       PAR_TYP,
    output logic       TX_OUT,
    output logic       BUSY,
    output logic       DONE
);

    function automatic logic [7:0] pick_byte(
        input cmd_type_e  t,
        input logic [1:0] idx,
        input logic [7:0] a0,
        input logic [7:0] a1,
        input logic [7:0] a2
    );
        logic [7:0] b;
        case (idx)
            2'd0:    b = opcode(t);
            2'd1:    b = (t == CMD_ALU_NOP) ? a2 : a0;
            2'd2:    b = a1;
            default: b = a2;
        endcase
        return b;
    endfunction

    cmd_type_e  r_type;
    logic [7:0] r_arg0;
    logic [7:0] r_arg1;
    logic [7:0] r_arg2;
    logic       r_par_en;
    logic       r_par_typ;
    logic       r_busy;
    logic       r_done;
    logic [1:0] r_byte_idx;

    cmd_type_e  w_in_type;
    logic [1:0] w_next_idx;
    logic       w_accept;
    logic       w_more;
    logic       w_byte_valid;
    logic       w_byte_ready;
    logic       w_frame_done;
    logic       w_par_en;
    logic       w_par_typ;
    logic [7:0] w_data;

    assign w_in_type  = cmd_type_e'(CMD_TYPE);
    assign w_accept   = CMD_VALID && !r_busy;
    assign w_next_idx = r_byte_idx + 2'd1;
    assign w_more     = r_busy &&
                        (({1'b0, r_byte_idx} + 3'd1) < seq_len(r_type));

    // The opcode goes straight from the inputs on the accept cycle so
    // the first start bit lands on the following edge.
    assign w_byte_valid = w_accept || w_more;
    assign w_data    = w_accept ? opcode(w_in_type)
                     : pick_byte(r_type, w_next_idx, r_arg0, r_arg1, r_arg2);
    assign w_par_en  = w_accept ? PAR_EN  : r_par_en;
    assign w_par_typ = w_accept ? PAR_TYP : r_par_typ;

    assign CMD_READY = !r_busy;
    assign BUSY      = r_busy;
    assign DONE      = r_done;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_type     <= CMD_RF_WR;
            r_arg0     <= '0;
            r_arg1     <= '0;
            r_arg2     <= '0;
            r_par_en   <= 1'b0;
            r_par_typ  <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_byte_idx <= '0;
        end else begin
            r_done <= w_frame_done;
            if (w_accept) begin
                r_type     <= w_in_type;
                r_arg0     <= ARG0;
                r_arg1     <= ARG1;
                r_arg2     <= ARG2;
                r_par_en   <= PAR_EN;
                r_par_typ  <= PAR_TYP;
                r_busy     <= 1'b1;
                r_byte_idx <= '0;
            end else if (w_frame_done) begin
                r_busy     <= 1'b0;
                r_byte_idx <= '0;
            end else if (w_more && w_byte_ready) begin
                r_byte_idx <= w_next_idx;
            end
        end
    end

    uart_frame_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_frame (
        .CLK       (CLK),
        .RST       (RST),
        .BYTE_VALID(w_byte_valid),
        .BYTE_READY(w_byte_ready),
        .DATA      (w_data),
        .PAR_EN    (w_par_en),
        .PAR_TYP   (w_par_typ),
        .TX_OUT    (TX_OUT),
        .FRAME_DONE(w_frame_done)
    );

endmodule

// File: doc/host_cmd_tx.md
# host_cmd_tx

Host-side command transmitter: the initiator end of the UART command link that the processing system's receive path and system controller decode. It accepts one command per handshake and expands it into the command byte sequence: RF write, RF read, ALU with operands, ALU without operands. It serializes each byte as a UART frame with optional parity on TX_OUT. It is used as the stimulus master in system benches and as a drop-in host-side controller.

## Interface
- CLKS_PER_BIT, default 16: CLK cycles per UART bit (legal 2..255).
- CLK  input  1  bit-rate reference clock; all logic on rising edge.
- RST  input  1  asynchronous, active-high reset.
- CMD_VALID  input  1  command request.
- CMD_READY  output  1  block can accept a command.
- CMD_TYPE  input  2  0 = RF write, 1 = RF read, 2 = ALU with operands, 3 = ALU without operands.
- ARG0  input  8  RF address, or ALU operand A.
- ARG1  input  8  RF write data, or ALU operand B.
- ARG2  input  8  ALU function code.
- PAR_EN  input  1  parity bit present when 1.
- PAR_TYP  input  1  0 = even parity, 1 = odd parity.
- TX_OUT  output  1  serial line, idle high.
- BUSY  output  1  command in progress.
- DONE  output  1  one-cycle pulse after the final stop bit.

## Operation
- Opcodes: RF write = 0xAA, RF read = 0xBB, ALU with operands = 0xCC, ALU without operands = 0xDD.
- Byte sequences:
  - RF write: 0xAA, ARG0, ARG1 (3 bytes).
  - RF read: 0xBB, ARG0 (2 bytes).
  - ALU with operands: 0xCC, ARG0, ARG1, ARG2 (4 bytes).
  - ALU without operands: 0xDD, ARG2 (2 bytes).
- Accept on CMD_VALID && CMD_READY. At acceptance, capture CMD_TYPE, ARG0..2, PAR_EN and PAR_TYP into registers. Input changes after acceptance have no effect.
- Frame format: start bit (0), then 8 data bits LSB first, then parity if PAR_EN, then one stop bit (1).
- Parity bit = XOR of the data bits, XOR PAR_TYP.
- Bytes are sent back-to-back. The next start bit immediately follows the previous stop bit; there is no idle gap.
- Frame FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE goes to START on accept.
  - START goes to DATA after CLKS_PER_BIT cycles.
  - DATA goes to PARITY (if PAR_EN) or STOP after 8 bits.
  - PARITY goes to STOP.
  - STOP goes to START if bytes remain, otherwise to IDLE and DONE is asserted.
- Counters:
  - Baud counter: 8 bits, counts 0..CLKS_PER_BIT-1.
  - Bit index: 3 bits.
  - Byte index: 2 bits, wraps at the sequence length.
- CMD_READY = (state == IDLE). BUSY = !CMD_READY.

## Timing
- Reset values: TX_OUT = 1, CMD_READY = 1, BUSY = 0, DONE = 0. All state returns to IDLE and all counters clear.
- TX_OUT is registered. If a command is accepted at edge k, TX_OUT falls at edge k+1.
- Each bit is held for exactly CLKS_PER_BIT cycles.
- Command duration = Nbytes × (10 + PAR_EN) × CLKS_PER_BIT cycles, measured from the first start-bit edge.
- DONE is high for the single cycle after the last stop-bit period. CMD_READY rises in the same cycle.
- Back-to-back commands: a command accepted in the DONE cycle drives its start bit on the next edge. The line holds exactly one stop-bit period of high between commands.
- CMD_VALID while BUSY is ignored. It is not queued.
- Reset mid-frame: TX_OUT returns high asynchronously and the partial command is dropped. No DONE is generated.

## Structure
- Package host_cmd_pkg holds:
  - the opcode localparams (0xAA/0xBB/0xCC/0xDD);
  - the cmd_type enum;
  - the frame-state enum;
  - a function returning sequence length per cmd_type.
- Sub-module uart_frame_tx is the single-byte serializer.
  - Byte-level interface: BYTE_VALID/BYTE_READY, DATA[7:0], PAR_EN, PAR_TYP, TX_OUT, FRAME_DONE.
  - It owns the baud and bit counters and the frame FSM.
- host_cmd_tx owns the command registers, the byte index, byte selection, DONE and CMD_READY.

## Test plan
- RF write, CLKS_PER_BIT = 16, PAR_EN = 0, ARG0 = 0x05, ARG1 = 0x3C -> line decodes 0xAA, 0x05, 0x3C. Duration is 480 cycles. DONE pulses once at cycle 481.
- RF read, PAR_EN = 1, PAR_TYP = 0, ARG0 = 0x02 -> frames 0xBB with parity 0, then 0x02 with parity 1. Duration is 352 cycles.
- ALU with operands, PAR_EN = 1, PAR_TYP = 1, ARG0 = 0x0A, ARG1 = 0x03, ARG2 = 0x00 -> bytes 0xCC (parity 1), 0x0A (parity 1), 0x03 (parity 1), 0x00 (parity 1). Duration is 704 cycles.
- ALU without operands (ARG2 = 0x01) is accepted during the DONE cycle of a prior command, and ARG2 is changed to 0xFF one cycle after acceptance -> the next start bit follows the previous stop bit with no gap, and the bytes sent are 0xDD, 0x01.
- CMD_VALID asserted while BUSY with a different CMD_TYPE -> CMD_READY stays 0, the request is ignored, and the in-flight sequence is unchanged.
- RST pulsed in the data bits of byte 2 -> TX_OUT = 1 immediately, BUSY = 0, no DONE. A new command after reset transmits correctly from its opcode.
